// File: rtl/pll_reset_sequencer.sv
// PLL reset supervisor: synchronises pll_locked and sequences mem/core resets on the board clock.
// Macro PLL_RESET_SEQ_RELOCK_EN enables the WAIT_LOCK timeout -> PLL_RST auto-relock path.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 4096,
  parameter int unsigned CORE_DELAY     = 256,
  parameter int unsigned LOCK_TIMEOUT   = 1048576,
  parameter int unsigned PLL_RST_CYCLES = 64
) (
  input  logic       clk_74a,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst_req,
  output logic       mem_reset,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] lock_lost_cnt,
  output logic [2:0] state_dbg
);

  localparam int unsigned MAX_A = (STABLE_CYCLES > CORE_DELAY) ? STABLE_CYCLES : CORE_DELAY;
  localparam int unsigned MAX_B = (LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW    = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_STABLE    = 3'd1,
    S_MEM_REL   = 3'd2,
    S_RUN       = 3'd3,
    S_CORE_HOLD = 3'd4
`ifdef PLL_RESET_SEQ_RELOCK_EN
    ,S_PLL_RST  = 3'd5
`endif
  } state_t;

  state_t                 state;
  state_t                 nxt;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   lock_loss;

  // pll_locked is asynchronous to clk_74a; only the last stage is consumed
  always_ff @(posedge clk_74a) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Next-state; lock conditions are tested before any timer expiry or soft request
  always_comb begin
    nxt       = state;
    lock_loss = 1'b0;
    case (state)
      S_WAIT_LOCK: begin
        if (locked_s) nxt = S_STABLE;
`ifdef PLL_RESET_SEQ_RELOCK_EN
        else if (timer == TW'(LOCK_TIMEOUT - 1)) nxt = S_PLL_RST;
`endif
      end
      S_STABLE: begin
        if (!locked_s) nxt = S_WAIT_LOCK;
        else if (timer == TW'(STABLE_CYCLES - 1)) nxt = S_MEM_REL;
      end
      S_MEM_REL: begin
        if (!locked_s) begin
          nxt       = S_WAIT_LOCK;
          lock_loss = 1'b1;
        end else if (timer == TW'(CORE_DELAY - 1)) begin
          nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          nxt       = S_WAIT_LOCK;
          lock_loss = 1'b1;
        end else if (soft_reset_req) begin
          nxt = S_CORE_HOLD;
        end
      end
      S_CORE_HOLD: begin
        if (!locked_s) begin
          nxt       = S_WAIT_LOCK;
          lock_loss = 1'b1;
        end else if (!soft_reset_req) begin
          nxt = S_MEM_REL;
        end
      end
`ifdef PLL_RESET_SEQ_RELOCK_EN
      S_PLL_RST: begin
        if (timer == TW'(PLL_RST_CYCLES - 1)) nxt = S_WAIT_LOCK;
      end
`endif
      default: nxt = S_WAIT_LOCK;
    endcase
  end

`ifdef PLL_RESET_SEQ_RELOCK_EN
  logic pll_rst_q;
  assign pll_rst_req = pll_rst_q;
`else
  assign pll_rst_req = 1'b0;
`endif

  // State, shared timer and outputs; outputs decode the next state so they move on state entry
  always_ff @(posedge clk_74a) begin
    if (rst) begin
      state         <= S_WAIT_LOCK;
      timer         <= '0;
      mem_reset     <= 1'b1;
      core_reset    <= 1'b1;
      ready         <= 1'b0;
      lock_lost_cnt <= 8'd0;
`ifdef PLL_RESET_SEQ_RELOCK_EN
      pll_rst_q     <= 1'b0;
`endif
    end else begin
      state      <= nxt;
      timer      <= (nxt != state) ? '0 : timer + TW'(1);
      mem_reset  <= (nxt == S_WAIT_LOCK) || (nxt == S_STABLE)
`ifdef PLL_RESET_SEQ_RELOCK_EN
                    || (nxt == S_PLL_RST)
`endif
                    ;
      core_reset <= (nxt != S_RUN);
      ready      <= (nxt == S_RUN);
`ifdef PLL_RESET_SEQ_RELOCK_EN
      pll_rst_q  <= (nxt == S_PLL_RST);
`endif
      if (lock_loss && (lock_lost_cnt != 8'hFF))
        lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with small timing parameters.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst_req;
  logic       mem_reset;
  logic       core_reset;
  logic       ready;
  logic [7:0] lock_lost_cnt;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(2), .STABLE_CYCLES(8), .CORE_DELAY(4),
    .LOCK_TIMEOUT(32), .PLL_RST_CYCLES(4)
  ) dut (
    .clk_74a(clk), .rst(rst), .pll_locked(pll_locked), .soft_reset_req(soft_reset_req),
    .pll_rst_req(pll_rst_req), .mem_reset(mem_reset), .core_reset(core_reset),
    .ready(ready), .lock_lost_cnt(lock_lost_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_mem_rel(input int budget);
    int n = 0;
    while (mem_reset !== 1'b0 && n < budget) begin step(1); n++; end
    chk("wait_mem_rel", 32'(mem_reset === 1'b0), 32'd1);
  endtask

  task automatic wait_state0(input int budget);
    int n = 0;
    while (state_dbg !== 3'd0 && n < budget) begin step(1); n++; end
    chk("wait_state0", 32'(state_dbg === 3'd0), 32'd1);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin step(1); n++; end
    chk("wait_ready", 32'(ready === 1'b1), 32'd1);
  endtask

  // Lock loss from an operating state: outputs change SYNC_STAGES+1 edges after the drop
  task automatic drop_lock_from_run();
    pll_locked = 1'b0;
    step(2);
    chk("loss_core_still0", 32'(core_reset), 32'd0);
    step(1);
    exp_cnt++;
    chk("loss_mem", 32'(mem_reset), 32'd1);
    chk("loss_core", 32'(core_reset), 32'd1);
    chk("loss_ready", 32'(ready), 32'd0);
    chk("loss_state", 32'(state_dbg), 32'd0);
    chk("loss_cnt", 32'(lock_lost_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b1; soft_reset_req = 1'b0;
    step(3);
    chk("rst_pll_rst_req", 32'(pll_rst_req), 32'd0);
    chk("rst_mem", 32'(mem_reset), 32'd1);
    chk("rst_core", 32'(core_reset), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_cnt", 32'(lock_lost_cnt), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);

    // Cold start: the last rst-high edge is cycle 0
    rst = 1'b0;
    step(10);
    chk("cold_mem_c10", 32'(mem_reset), 32'd1);
    chk("cold_state_c10", 32'(state_dbg), 32'd1);
    step(1);
    chk("cold_mem_c11", 32'(mem_reset), 32'd0);
    chk("cold_state_c11", 32'(state_dbg), 32'd2);
    step(3);
    chk("cold_core_c14", 32'(core_reset), 32'd1);
    chk("cold_ready_c14", 32'(ready), 32'd0);
    step(1);
    chk("cold_core_c15", 32'(core_reset), 32'd0);
    chk("cold_ready_c15", 32'(ready), 32'd1);
    chk("cold_state_c15", 32'(state_dbg), 32'd3);

    // Lock loss in RUN, then re-lock replays cold-start timing
    drop_lock_from_run();
    pll_locked = 1'b1;
    step(10);
    chk("relock_mem_c10", 32'(mem_reset), 32'd1);
    step(1);
    chk("relock_mem_c11", 32'(mem_reset), 32'd0);
    step(3);
    chk("relock_core_c14", 32'(core_reset), 32'd1);
    step(1);
    chk("relock_core_c15", 32'(core_reset), 32'd0);
    chk("relock_ready_c15", 32'(ready), 32'd1);

    // Soft reset held 10 cycles: core held, memory untouched
    soft_reset_req = 1'b1;
    step(1);
    chk("soft_core", 32'(core_reset), 32'd1);
    chk("soft_ready", 32'(ready), 32'd0);
    chk("soft_mem", 32'(mem_reset), 32'd0);
    chk("soft_state", 32'(state_dbg), 32'd4);
    step(9);
    chk("soft_core_hold", 32'(core_reset), 32'd1);
    chk("soft_mem_hold", 32'(mem_reset), 32'd0);
    soft_reset_req = 1'b0;
    // One edge to leave CORE_HOLD, then CORE_DELAY cycles in MEM_REL
    step(4);
    chk("soft_rel_core_d4", 32'(core_reset), 32'd1);
    chk("soft_rel_state_d4", 32'(state_dbg), 32'd2);
    chk("soft_rel_mem_d4", 32'(mem_reset), 32'd0);
    step(1);
    chk("soft_rel_core_d5", 32'(core_reset), 32'd0);
    chk("soft_rel_ready_d5", 32'(ready), 32'd1);
    chk("soft_cnt", 32'(lock_lost_cnt), 32'(exp_cnt));

    // One-cycle lock glitch in STABLE restarts the STABLE count
    drop_lock_from_run();
    pll_locked = 1'b1;
    step(8);
    chk("glitch_state_pre", 32'(state_dbg), 32'd1);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(2);
    chk("glitch_state_wait", 32'(state_dbg), 32'd0);
    chk("glitch_mem_wait", 32'(mem_reset), 32'd1);
    chk("glitch_cnt", 32'(lock_lost_cnt), 32'(exp_cnt));
    step(8);
    chk("glitch_mem_c19", 32'(mem_reset), 32'd1);
    chk("glitch_state_c19", 32'(state_dbg), 32'd1);
    step(1);
    chk("glitch_mem_c20", 32'(mem_reset), 32'd0);
    chk("glitch_cnt_after", 32'(lock_lost_cnt), 32'(exp_cnt));
    step(4);
    chk("glitch_ready_c24", 32'(ready), 32'd1);

    // Lock held low: auto-relock pulses only in the relock build
    drop_lock_from_run();
`ifdef PLL_RESET_SEQ_RELOCK_EN
    step(31);
    chk("relock_req_w31", 32'(pll_rst_req), 32'd0);
    chk("relock_state_w31", 32'(state_dbg), 32'd0);
    step(1);
    chk("relock_req_w32", 32'(pll_rst_req), 32'd1);
    chk("relock_state_w32", 32'(state_dbg), 32'd5);
    chk("relock_mem_w32", 32'(mem_reset), 32'd1);
    step(3);
    chk("relock_req_w35", 32'(pll_rst_req), 32'd1);
    step(1);
    chk("relock_req_w36", 32'(pll_rst_req), 32'd0);
    chk("relock_state_w36", 32'(state_dbg), 32'd0);
    step(31);
    chk("relock_req_w67", 32'(pll_rst_req), 32'd0);
    step(1);
    chk("relock_req_w68", 32'(pll_rst_req), 32'd1);
    step(4);
    chk("relock_req_w72", 32'(pll_rst_req), 32'd0);
`else
    for (int i = 0; i < 80; i++) begin
      step(1);
      chk("norelock_req", 32'(pll_rst_req), 32'd0);
    end
    chk("norelock_state", 32'(state_dbg), 32'd0);
`endif

    // rst in RUN restores every reset value on the next edge
    pll_locked = 1'b1;
    wait_ready(200);
    rst = 1'b1;
    step(1);
    chk("midrst_mem", 32'(mem_reset), 32'd1);
    chk("midrst_core", 32'(core_reset), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_cnt", 32'(lock_lost_cnt), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'd0);
    chk("midrst_pll_rst_req", 32'(pll_rst_req), 32'd0);
    rst = 1'b0;

    // 300 lock losses in MEM_REL saturate the counter at 255
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b1;
      wait_mem_rel(100);
      pll_locked = 1'b0;
      wait_state0(20);
      if (i == 1)   chk("sat_cnt_1", 32'(lock_lost_cnt), 32'd1);
      if (i == 254) chk("sat_cnt_254", 32'(lock_lost_cnt), 32'd254);
      if (i == 255) chk("sat_cnt_255", 32'(lock_lost_cnt), 32'd255);
    end
    chk("sat_cnt_300", 32'(lock_lost_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
